// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/return stage.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef logic [2:0] div_state_t;

  localparam div_state_t ST_IDLE  = 3'd0;
  localparam div_state_t ST_START = 3'd1;
  localparam div_state_t ST_WAIT  = 3'd2;
  localparam div_state_t ST_RESP  = 3'd3;
  localparam div_state_t ST_DRAIN = 3'd4;

  // Constants are built at the widest supported width and sliced by the user.
  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] div_by_zero_quo(input int unsigned w);
    div_by_zero_quo = (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [MAX_W-1:0] int_min(input int unsigned w);
    int_min = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of two values; used for operand
// magnitudes and for quotient/remainder sign correction.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             neg_b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  assign a_o = neg_a_i ? -a_i : a_i;
  assign b_o = neg_b_i ? -b_i : b_i;

endmodule

// File: rtl/div_seq_ctrl.sv
// Issue/return stage for the external iterative unsigned divider: handles
// signs, divide-by-zero and overflow, and returns a tagged result.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [WIDTH-1:0] req_a_i,
  input  logic [WIDTH-1:0] req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             div_start_o,
  output logic [WIDTH-1:0] div_a_o,
  output logic [WIDTH-1:0] div_b_o,
  input  logic             div_done_i,
  input  logic [WIDTH-1:0] div_quo_i,
  input  logic [WIDTH-1:0] div_rem_i
);
  import div_pkg::*;

  localparam logic [MAX_W-1:0] QUO_Z_FULL   = div_by_zero_quo(WIDTH);
  localparam logic [MAX_W-1:0] INT_MIN_FULL = int_min(WIDTH);
  localparam logic [WIDTH-1:0] QUO_Z        = QUO_Z_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INT_MIN      = INT_MIN_FULL[WIDTH-1:0];

  div_state_t       state_q, state_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;

  div_op_e          req_op;
  logic             req_signed, req_rem;
  logic             req_neg_a, req_neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign req_op     = div_op_e'(req_op_i);
  assign req_signed = (req_op == DIV) || (req_op == REM);
  assign req_rem    = (req_op == REM) || (req_op == REMU);
  assign req_neg_a  = req_signed & req_a_i[WIDTH-1];
  assign req_neg_b  = req_signed & req_b_i[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_pre_fix (
    .a_i     (req_a_i),
    .neg_a_i (req_neg_a),
    .b_i     (req_b_i),
    .neg_b_i (req_neg_b),
    .a_o     (mag_a),
    .b_o     (mag_b)
  );

  // Quotient takes the XOR of the signs, remainder follows the dividend.
  div_sign_fix #(.WIDTH(WIDTH)) u_post_fix (
    .a_i     (div_quo_i),
    .neg_a_i (neg_a_q ^ neg_b_q),
    .b_i     (div_rem_i),
    .neg_b_i (neg_a_q),
    .a_o     (quo_fix),
    .b_o     (rem_fix)
  );

  always_comb begin
    state_d  = state_q;
    is_rem_d = is_rem_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    data_d   = data_q;
    tag_d    = tag_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i && req_valid_i) begin
          is_rem_d = req_rem;
          neg_a_d  = req_neg_a;
          neg_b_d  = req_neg_b;
          tag_d    = req_tag_i;
          if (req_b_i == '0) begin
            data_d  = req_rem ? req_a_i : QUO_Z;
            state_d = ST_RESP;
          end else if (req_signed && req_a_i == INT_MIN && req_b_i == QUO_Z) begin
            data_d  = req_rem ? '0 : req_a_i;
            state_d = ST_RESP;
          end else begin
            div_a_d = mag_a;
            div_b_d = mag_b;
            state_d = ST_START;
          end
        end
      end
      // The start pulse leaves this cycle regardless, so a flush must drain.
      ST_START: state_d = flush_i ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (flush_i) begin
          // A done arriving with the flush is already consumed; nothing to drain.
          state_d = div_done_i ? ST_IDLE : ST_DRAIN;
        end else if (div_done_i) begin
          data_d  = is_rem_q ? rem_fix : quo_fix;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush_i || rsp_ready_i) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      is_rem_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      div_a_q  <= '0;
      div_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      is_rem_q <= is_rem_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      div_a_q  <= div_a_d;
      div_b_q  <= div_b_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign div_start_o = (state_q == ST_START);
  assign rsp_data_o  = data_q;
  assign rsp_tag_o   = tag_q;
  assign div_a_o     = div_a_q;
  assign div_b_o     = div_b_q;

endmodule
